// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage of the pipelined MIPS core.
// It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO against the architectural HI/LO pair
// and reports busy to the hazard unit.
// Optional build macro MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU (op 6..9) accumulate ops.
module md_unit #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        is_mul, is_div, is_mthi, is_mtlo, is_signed;
`ifdef MD_MADD_EN
  logic        is_acc, is_sub;
`endif

  logic [63:0] a_ext, b_ext, prod, mul_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [63:0] div_res;

  // Op decode; reserved codes leave every strobe low so they have no effect.
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    is_signed = 1'b0;
`ifdef MD_MADD_EN
    is_acc    = 1'b0;
    is_sub    = 1'b0;
`endif
    case (op)
      4'd0: begin is_mul = 1'b1; is_signed = 1'b1; end
      4'd1: is_mul = 1'b1;
      4'd2: begin is_div = 1'b1; is_signed = 1'b1; end
      4'd3: is_div = 1'b1;
      4'd4: is_mthi = 1'b1;
      4'd5: is_mtlo = 1'b1;
`ifdef MD_MADD_EN
      4'd6: begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
      4'd7: begin is_mul = 1'b1; is_acc = 1'b1; end
      4'd8: begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      4'd9: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Multiply: sign- or zero-extend to 64 bits so the low 64 product bits are exact.
  always_comb begin
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    prod  = a_ext * b_ext;
`ifdef MD_MADD_EN
    if (is_acc)
      mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    else
      mul_res = prod;
`else
    mul_res = prod;
`endif
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder follows the dividend. 0x80000000 / -1 falls out naturally as
  // the negated magnitude wraps back to 0x80000000. Divide by zero is overridden.
  always_comb begin
    a_neg   = is_signed & a[31];
    b_neg   = is_signed & b[31];
    a_mag   = a_neg ? (~a + 32'd1) : a;
    b_mag   = b_neg ? (~b + 32'd1) : b;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quo     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
    div_res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
  end

  assign accept = start & (state_q == S_IDLE);

  // State register plus the datapath flops it sequences.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: long ops enter RUN, leave on the counter's final cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (is_mul || is_div)) state_d = S_RUN;
      S_RUN:   if (cnt_q <= 4'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the result on accept, count down, commit to HI/LO at the end.
  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        res_d = mul_res;
        cnt_d = 4'(MUL_LAT);
      end
      if (accept && is_div) begin
        res_d = div_res;
        cnt_d = 4'(DIV_LAT);
      end
      if (accept && is_mthi) hi_d = a;
      if (accept && is_mtlo) lo_d = a;
    end else begin
      if (cnt_q <= 4'd1) begin
        {hi_d, lo_d} = res_q;
        cnt_d        = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Outputs: busy reflects RUN; md_pending is purely combinational.
  always_comb begin
    busy       = (state_q == S_RUN);
    md_pending = start | busy;
    hi         = hi_q;
    lo         = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven directed bench for md_unit plus hand-written sequences
// for ignored starts, back-to-back MTLO/MTHI, mid-operation reset and accumulate ops.
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_pending;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .md_pending (md_pending),
    .hi         (hi),
    .lo         (lo)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  // Compare one value against its expectation and tally the result
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op for one edge, then count busy cycles and watch HI/LO hold
  task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                output int cyc, output logic held);
    logic [31:0] h0, l0;
    h0   = hi;
    l0   = lo;
    held = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cyc   = 0;
    while (busy && cyc < 40) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    logic        held;
    logic        pend_ok;
    logic        busy_seen;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{4'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 10};
    vecs[3]  = '{4'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5]  = '{4'd3, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10};
    vecs[6]  = '{4'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{4'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 5};
    vecs[8]  = '{4'd2, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10};
    vecs[9]  = '{4'd4, 32'h1234_5678, 32'd9,        32'h1234_5678, 32'hFFFF_FFFF, 0};
    vecs[10] = '{4'd5, 32'hCAFE_BABE, 32'd9,        32'h1234_5678, 32'hCAFE_BABE, 0};
    vecs[11] = '{4'd10, 32'd1,        32'd1,        32'h1234_5678, 32'hCAFE_BABE, 0};
`ifdef MD_MADD_EN
    vecs[12] = '{4'd6, 32'd2,         32'd3,        32'h1234_5678, 32'hCAFE_BAC4, 5};
`else
    vecs[12] = '{4'd6, 32'd2,         32'd3,        32'h1234_5678, 32'hCAFE_BABE, 0};
`endif

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    a       = 32'd0;
    b       = 32'd0;
    #2;
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_pending", {31'd0, md_pending}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
      check_output($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check_output($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check_output($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      if (vecs[i].exp_cyc > 0)
        check_output($sformatf("vec%0d_hold_before_commit", i), {31'd0, held}, 32'd1);
    end

    // DIV 100/7 with MTHI then MULT presented during cycles 3 and 4 of the run
    @(negedge clk);
    start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pend_ok = 1'b1;
    cyc     = 0;
    while (busy && cyc < 40) begin
      if (!md_pending) pend_ok = 1'b0;
      @(negedge clk);
      if (cyc == 2) begin
        start = 1'b1; op = 4'd4; a = 32'h1234; b = 32'd0;
      end else if (cyc == 3) begin
        start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
      end else begin
        start = 1'b0;
      end
      #1;
      if (!md_pending) pend_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_output("ignored_busy_cycles", 32'(cyc), 32'd10);
    check_output("ignored_hi", hi, 32'd2);
    check_output("ignored_lo", lo, 32'd14);
    check_output("ignored_pending", {31'd0, pend_ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_output("ignored_no_restart", {31'd0, busy}, 32'd0);

    // MTLO then MTHI on consecutive edges; busy must never rise
    busy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    if (busy) busy_seen = 1'b1;
    check_output("mtlo_lo", lo, 32'hCAFE_BABE);
    check_output("mtlo_hi_kept", hi, 32'd2);
    @(negedge clk);
    op = 4'd4; a = 32'h1;
    @(posedge clk);
    #1;
    if (busy) busy_seen = 1'b1;
    start = 1'b0;
    check_output("mthi_hi", hi, 32'h1);
    check_output("mthi_lo_kept", lo, 32'hCAFE_BABE);
    check_output("mt_never_busy", {31'd0, busy_seen}, 32'd0);

    // md_pending follows start combinationally while idle
    @(negedge clk);
    start = 1'b1; op = 4'd10;
    #1;
    check_output("pending_comb_hi", {31'd0, md_pending}, 32'd1);
    start = 1'b0;
    #1;
    check_output("pending_comb_lo", {31'd0, md_pending}, 32'd0);

    // MULT 3*4 interrupted by reset during its second cycle
    @(negedge clk);
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("midreset_hi", hi, 32'd0);
    check_output("midreset_lo", lo, 32'd0);
    check_output("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_output("no_late_commit_hi", hi, 32'd0);
    check_output("no_late_commit_lo", lo, 32'd0);
    check_output("no_late_commit_busy", {31'd0, busy}, 32'd0);

`ifdef MD_MADD_EN
    // Accumulate carries across the 32-bit boundary, then subtract back
    apply_stimulus(4'd4, 32'd0, 32'd0, cyc, held);
    apply_stimulus(4'd5, 32'hFFFF_FFFF, 32'd0, cyc, held);
    apply_stimulus(4'd7, 32'd1, 32'd1, cyc, held);
    check_output("maddu_cycles", 32'(cyc), 32'd5);
    check_output("maddu_hi", hi, 32'd1);
    check_output("maddu_lo", lo, 32'd0);
    apply_stimulus(4'd8, 32'hFFFF_FFFF, 32'd2, cyc, held);
    check_output("msub_hi", hi, 32'd1);
    check_output("msub_lo", lo, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
